// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end: the opcodes the jump control
// block decodes, the interrupt controller state encoding, the ISR vector
// width and a helper that turns a source index into its ISR address.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int ADDR_W = 16;

   localparam logic [5:0] OP_RETI = 6'b011110;
   localparam logic [5:0] OP_JMP  = 6'b011000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   // ISR address of a source: base + (id << stride_log2), wrapping mod 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] isr_addr(
      input logic [ADDR_W-1:0] base,
      input logic [2:0]        id,
      input int unsigned       stride_log2
   );
      return base + (ADDR_W'(id) << stride_log2);
   endfunction

endpackage

// File: rtl/int_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// int_req_ctrl_if
// Link between the interrupt request controller and the jump control block.
//   interrupt   : controller -> jump ctrl, one-cycle request pulse
//   isr_vector  : controller -> jump ctrl, ISR target address
//   int_active  : controller -> jump ctrl, ISR in service
//   active_id   : controller -> jump ctrl, index of the serviced source
//   op          : jump ctrl  -> controller, opcode in the execute stage
//   pc_mux_sel  : jump ctrl  -> controller, jump-taken indication
//
// Handshake: the controller raises `interrupt` for exactly one cycle with
// isr_vector already valid; there is no back-pressure. The jump control
// block is expected to take the jump (pc_mux_sel=1) in the following cycle;
// the controller only observes that acknowledgement. Service ends when op
// carries OP_RETI while int_active is high in the service phase.
// ---------------------------------------------------------------------------
interface int_req_ctrl_if;
   import cpu_pkg::*;

   logic              interrupt;
   logic [ADDR_W-1:0] isr_vector;
   logic              int_active;
   logic [2:0]        active_id;
   logic [5:0]        op;
   logic              pc_mux_sel;

   modport master (
      output interrupt, isr_vector, int_active, active_id,
      input  op, pc_mux_sel
   );

   modport slave (
      input  interrupt, isr_vector, int_active, active_id,
      output op, pc_mux_sel
   );

endinterface

// File: rtl/int_req_ctrl_prio_enc.sv
// ---------------------------------------------------------------------------
// prio_enc
// Combinational fixed-priority encoder; the lowest set index wins.
//   req   : request vector
//   valid : at least one request bit set
//   id    : index of the winning request (0 when valid=0)
// ---------------------------------------------------------------------------
module prio_enc #(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [2:0]         id
);

   // Scan from the top down so the lowest set index is the last assignment.
   always_comb begin
      valid = 1'b0;
      id    = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = 3'(i);
         end
      end
   end

endmodule

// File: rtl/int_req_ctrl.sv
// ---------------------------------------------------------------------------
// int_req_ctrl
// Interrupt request controller feeding the jump control block. Rising edges
// on irq_in are latched as pending, masked, and the lowest-index eligible
// source is issued as a one-cycle interrupt pulse carrying its ISR vector.
// Further requests are held off until the pipeline executes OP_RETI.
//   clk, reset  : clock, synchronous active-high reset
//   irq_in      : raw request lines (synchronous to clk)
//   mask_we     : mask register write strobe
//   mask_wdata  : new mask value (1 = masked)
//   pending     : latched, not-yet-serviced requests
//   mask        : current mask register
//   state_dbg   : FSM state, for observation only
//   jc          : link to the jump control block (see int_req_ctrl_if)
// ---------------------------------------------------------------------------
module int_req_ctrl
   import cpu_pkg::*;
#(
   parameter int                NUM_SRC         = 4,
   parameter logic [ADDR_W-1:0] VEC_BASE        = 16'h0040,
   parameter int                VEC_STRIDE_LOG2 = 2,
   parameter logic [NUM_SRC-1:0] MASK_RST       = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] mask,
   output state_e             state_dbg,
   int_req_ctrl_if.master     jc
);

   state_e              state_q, state_d;
   logic [NUM_SRC-1:0]  irq_prev_q, irq_prev_d;
   logic [NUM_SRC-1:0]  pending_q, pending_d;
   logic [NUM_SRC-1:0]  mask_q, mask_d;
   logic [2:0]          active_id_q, active_id_d;
   logic [ADDR_W-1:0]   isr_vector_q, isr_vector_d;
   logic                was_req_q, was_req_d;
   logic                lost_ack_q, lost_ack_d;

   logic [NUM_SRC-1:0]  rise;
   logic [NUM_SRC-1:0]  eligible;
   logic [NUM_SRC-1:0]  clr;
   logic                win_valid;
   logic [2:0]          win_id;
   logic                reti;
   logic                interrupt_c;
   logic                int_active_c;

   assign eligible = pending_q & ~mask_q;

   prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
      .req   (eligible),
      .valid (win_valid),
      .id    (win_id)
   );

   // FSM next state and outputs
   always_comb begin
      state_d      = state_q;
      active_id_d  = active_id_q;
      isr_vector_d = isr_vector_q;
      interrupt_c  = 1'b0;
      int_active_c = 1'b0;
      reti         = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d      = REQ;
               active_id_d  = win_id;
               isr_vector_d = isr_addr(VEC_BASE, win_id, VEC_STRIDE_LOG2);
            end
         end
         REQ: begin
            interrupt_c  = 1'b1;
            int_active_c = 1'b1;
            state_d      = SERVICE;
         end
         SERVICE: begin
            int_active_c = 1'b1;
            if (jc.op == OP_RETI) begin
               reti    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Edge detect, pending and mask. The clear is applied before the set so a
   // fresh edge in the RETI cycle keeps the serviced source pending.
   always_comb begin
      rise       = irq_in & ~irq_prev_q;
      irq_prev_d = irq_in;
      clr        = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         clr[i] = reti && (active_id_q == 3'(i));
      end
      pending_d  = (pending_q & ~clr) | rise;
      mask_d     = mask_we ? mask_wdata : mask_q;
   end

   // The jump should be taken in the cycle right after the REQ pulse; a
   // missing pc_mux_sel there is remembered until reset.
   always_comb begin
      was_req_d  = (state_q == REQ);
      lost_ack_d = lost_ack_q | (was_req_q & ~jc.pc_mux_sel);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         irq_prev_q   <= '0;
         pending_q    <= '0;
         mask_q       <= MASK_RST;
         active_id_q  <= 3'd0;
         isr_vector_q <= '0;
         was_req_q    <= 1'b0;
         lost_ack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         irq_prev_q   <= irq_prev_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         active_id_q  <= active_id_d;
         isr_vector_q <= isr_vector_d;
         was_req_q    <= was_req_d;
         lost_ack_q   <= lost_ack_d;
      end
   end

   assign jc.interrupt  = interrupt_c;
   assign jc.int_active = int_active_c;
   assign jc.active_id  = active_id_q;
   assign jc.isr_vector = isr_vector_q;
   assign pending       = pending_q;
   assign mask          = mask_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_int_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_req_ctrl
// Directed bench for int_req_ctrl with NUM_SRC=4, VEC_BASE=16'h0040,
// VEC_STRIDE_LOG2=2. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, so each step() shows the state
// produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_int_req_ctrl;
   import cpu_pkg::*;

   logic       clk;
   logic       reset;
   logic [3:0] irq_in;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic [3:0] pending;
   logic [3:0] mask;
   state_e     state_dbg;

   int checks;
   int failures;

   int_req_ctrl_if jc_if ();

   int_req_ctrl #(
      .NUM_SRC         (4),
      .VEC_BASE        (16'h0040),
      .VEC_STRIDE_LOG2 (2),
      .MASK_RST        (4'hF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .pending    (pending),
      .mask       (mask),
      .state_dbg  (state_dbg),
      .jc         (jc_if)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [3:0] value);
      mask_we    = 1'b1;
      mask_wdata = value;
      step();
      mask_we    = 1'b0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      irq_in = 4'b0101;
      step();
      irq_in = 4'b1010;
      step();
      checks++; if (jc_if.interrupt !== 1'b0) begin failures++; $display("FAIL reset_interrupt: got %b want 0", jc_if.interrupt); end
      checks++; if (jc_if.isr_vector !== 16'h0000) begin failures++; $display("FAIL reset_vector: got %h want 0000", jc_if.isr_vector); end
      checks++; if (jc_if.int_active !== 1'b0) begin failures++; $display("FAIL reset_int_active: got %b want 0", jc_if.int_active); end
      checks++; if (jc_if.active_id !== 3'd0) begin failures++; $display("FAIL reset_active_id: got %0d want 0", jc_if.active_id); end
      checks++; if (pending !== 4'h0) begin failures++; $display("FAIL reset_pending: got %b want 0000", pending); end
      checks++; if (mask !== 4'hF) begin failures++; $display("FAIL reset_mask: got %h want F", mask); end
      checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
      irq_in = 4'b0000;
      reset  = 1'b0;
      begin
         int pulses = 0;
         for (int i = 0; i < 10; i++) begin
            step();
            if (jc_if.interrupt === 1'b1) pulses++;
         end
         checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_no_pulse: got %0d pulses want 0", pulses); end
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_single();
      write_mask(4'h0);
      checks++; if (mask !== 4'h0) begin failures++; $display("FAIL single_mask: got %h want 0", mask); end
      irq_in = 4'b0100;
      step();
      checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL single_pending: got %b want 0100", pending); end
      checks++; if (jc_if.interrupt !== 1'b0) begin failures++; $display("FAIL single_early: got %b want 0", jc_if.interrupt); end
      step();
      checks++; if (jc_if.interrupt !== 1'b1) begin failures++; $display("FAIL single_pulse: got %b want 1", jc_if.interrupt); end
      checks++; if (jc_if.isr_vector !== 16'h0048) begin failures++; $display("FAIL single_vector: got %h want 0048", jc_if.isr_vector); end
      checks++; if (jc_if.active_id !== 3'd2) begin failures++; $display("FAIL single_id: got %0d want 2", jc_if.active_id); end
      checks++; if (jc_if.int_active !== 1'b1) begin failures++; $display("FAIL single_active_req: got %b want 1", jc_if.int_active); end
      jc_if.pc_mux_sel = 1'b1;
      step();
      jc_if.pc_mux_sel = 1'b0;
      checks++; if (jc_if.interrupt !== 1'b0) begin failures++; $display("FAIL single_pulse_width: got %b want 0", jc_if.interrupt); end
      checks++; if (jc_if.int_active !== 1'b1) begin failures++; $display("FAIL single_active_svc: got %b want 1", jc_if.int_active); end
      step();
      step();
      checks++; if (jc_if.isr_vector !== 16'h0048 || jc_if.active_id !== 3'd2 || state_dbg !== SERVICE) begin failures++; $display("FAIL single_hold: got vec %h id %0d state %0d want 0048 2 2", jc_if.isr_vector, jc_if.active_id, state_dbg); end
      jc_if.op = OP_RETI;
      irq_in   = 4'b0000;
      step();
      jc_if.op = 6'd0;
      checks++; if (jc_if.int_active !== 1'b0) begin failures++; $display("FAIL single_reti_active: got %b want 0", jc_if.int_active); end
      checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL single_reti_pending: got %b want 0000", pending); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_back_to_back();
      irq_in = 4'b1010;
      step();
      checks++; if (pending !== 4'b1010) begin failures++; $display("FAIL b2b_pending: got %b want 1010", pending); end
      step();
      checks++; if (jc_if.interrupt !== 1'b1 || jc_if.active_id !== 3'd1 || jc_if.isr_vector !== 16'h0044) begin failures++; $display("FAIL b2b_first: got irq %b id %0d vec %h want 1 1 0044", jc_if.interrupt, jc_if.active_id, jc_if.isr_vector); end
      step();
      jc_if.op = OP_RETI;
      step();
      jc_if.op = 6'd0;
      checks++; if (pending !== 4'b1000) begin failures++; $display("FAIL b2b_pending_after_reti: got %b want 1000", pending); end
      checks++; if (jc_if.interrupt !== 1'b0) begin failures++; $display("FAIL b2b_gap: got %b want 0", jc_if.interrupt); end
      step();
      checks++; if (jc_if.interrupt !== 1'b1 || jc_if.active_id !== 3'd3 || jc_if.isr_vector !== 16'h004C) begin failures++; $display("FAIL b2b_second: got irq %b id %0d vec %h want 1 3 004c", jc_if.interrupt, jc_if.active_id, jc_if.isr_vector); end
      step();
      jc_if.op = OP_RETI;
      irq_in   = 4'b0000;
      step();
      jc_if.op = 6'd0;
      checks++; if (pending !== 4'b0000 || state_dbg !== IDLE) begin failures++; $display("FAIL b2b_done: got pending %b state %0d want 0000 0", pending, state_dbg); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_masked();
      write_mask(4'b0001);
      irq_in = 4'b0001;
      step();
      checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL masked_pending: got %b want 0001", pending); end
      begin
         int pulses = 0;
         for (int i = 0; i < 4; i++) begin
            step();
            if (jc_if.interrupt === 1'b1) pulses++;
         end
         checks++; if (pulses !== 0) begin failures++; $display("FAIL masked_no_pulse: got %0d pulses want 0", pulses); end
      end
      write_mask(4'b0000);
      checks++; if (jc_if.interrupt !== 1'b0) begin failures++; $display("FAIL unmask_select: got %b want 0", jc_if.interrupt); end
      step();
      checks++; if (jc_if.interrupt !== 1'b1 || jc_if.active_id !== 3'd0 || jc_if.isr_vector !== 16'h0040) begin failures++; $display("FAIL unmask_pulse: got irq %b id %0d vec %h want 1 0 0040", jc_if.interrupt, jc_if.active_id, jc_if.isr_vector); end
      step();
      jc_if.op = OP_RETI;
      irq_in   = 4'b0000;
      step();
      jc_if.op = 6'd0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reti_reedge();
      irq_in = 4'b0100;
      step();
      step();
      checks++; if (jc_if.interrupt !== 1'b1 || jc_if.isr_vector !== 16'h0048) begin failures++; $display("FAIL reedge_first: got irq %b vec %h want 1 0048", jc_if.interrupt, jc_if.isr_vector); end
      step();
      irq_in = 4'b0000;
      step();
      irq_in   = 4'b0100;
      jc_if.op = OP_RETI;
      step();
      jc_if.op = 6'd0;
      checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL reedge_pending: got %b want 0100", pending); end
      checks++; if (jc_if.int_active !== 1'b0) begin failures++; $display("FAIL reedge_inactive: got %b want 0", jc_if.int_active); end
      step();
      checks++; if (jc_if.interrupt !== 1'b1 || jc_if.active_id !== 3'd2 || jc_if.isr_vector !== 16'h0048) begin failures++; $display("FAIL reedge_again: got irq %b id %0d vec %h want 1 2 0048", jc_if.interrupt, jc_if.active_id, jc_if.isr_vector); end
      step();
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid_service();
      irq_in = 4'b0110;
      step();
      checks++; if (state_dbg !== SERVICE || pending !== 4'b0110) begin failures++; $display("FAIL midrst_before: got state %0d pending %b want 2 0110", state_dbg, pending); end
      reset  = 1'b1;
      irq_in = 4'b0000;
      step();
      reset  = 1'b0;
      checks++; if (jc_if.int_active !== 1'b0) begin failures++; $display("FAIL midrst_active: got %b want 0", jc_if.int_active); end
      checks++; if (pending !== 4'h0) begin failures++; $display("FAIL midrst_pending: got %b want 0000", pending); end
      checks++; if (mask !== 4'hF) begin failures++; $display("FAIL midrst_mask: got %h want F", mask); end
      checks++; if (jc_if.isr_vector !== 16'h0000 || jc_if.active_id !== 3'd0) begin failures++; $display("FAIL midrst_vector: got vec %h id %0d want 0000 0", jc_if.isr_vector, jc_if.active_id); end
      jc_if.op = OP_RETI;
      step();
      jc_if.op = 6'd0;
      checks++; if (state_dbg !== IDLE || jc_if.int_active !== 1'b0 || pending !== 4'h0) begin failures++; $display("FAIL midrst_reti: got state %0d active %b pending %b want 0 0 0000", state_dbg, jc_if.int_active, pending); end
      begin
         int pulses = 0;
         for (int i = 0; i < 5; i++) begin
            step();
            if (jc_if.interrupt === 1'b1) pulses++;
         end
         checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", pulses); end
      end
   endtask

   // ------------------------------------------------------------------
   initial begin
      checks           = 0;
      failures         = 0;
      reset            = 1'b1;
      irq_in           = 4'b0000;
      mask_we          = 1'b0;
      mask_wdata       = 4'h0;
      jc_if.op         = 6'd0;
      jc_if.pc_mux_sel = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_masked();
      test_reti_reedge();
      test_reset_mid_service();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
